// File: rtl/seg_scan_if.sv
// seg_scan_if: display bus between a value source and the seg_scan scanner.
// master drives the value, the decimal points and the load/enable controls;
// slave (the scanner) drives the decoder nibble, the anodes and the dp.
interface seg_scan_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic                en;
   logic [3:0]          nibble;
   logic [DIGITS-1:0]   an;
   logic                dp;

   modport master (output value, dp_in, load, en, input nibble, an, dp);
   modport slave  (input value, dp_in, load, en, output nibble, an, dp);
endinterface

// File: rtl/seg_scan.sv
// seg_scan: multiplexed common-anode display scanner.
// Holds a shadow copy of a DIGITS-nibble hex value and gives each digit a slot
// of DIV cycles. For DIV-1 cycles of the slot the digit is lit. The last cycle
// of the slot is an all-anodes-off guard that suppresses ghosting while the
// digit changes. All outputs are registered.
// Optional build macro SEG_SCAN_LZB_EN: leading-zero blanking. Digits above
// the most significant nonzero nibble stay dark. Digit 0 always lights.
module seg_scan #(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000
) (
   input  logic       clk,
   input  logic       rst,
   seg_scan_if.slave  bus
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

   logic [DIGITS-1:0][3:0] sv;
   logic [DIGITS-1:0]      sd;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic                   tick;
   logic                   blank;
   logic                   lit;

   // last cycle of an enabled slot: this edge is the guard edge and idx moves on
   assign tick = bus.en && (cnt == CNT_MAX);

`ifdef SEG_SCAN_LZB_EN
   logic [IW-1:0] msd;

   // index of the highest nonzero shadow nibble; 0 when all nibbles are zero
   always_comb begin
      msd = '0;
      for (int i = 1; i < DIGITS; i++)
         if (sv[i] != 4'h0) msd = IW'(i);
   end

   assign blank = (idx > msd);
`else
   assign blank = 1'b0;
`endif

   assign lit = bus.en && !tick && !blank;

   // shadow registers; loading ignores en so the host can update a dark display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sv <= '0;
         sd <= '0;
      end else if (bus.load) begin
         sv <= bus.value;
         sd <= bus.dp_in;
      end
   end

   // slot prescaler and digit index; both freeze while en is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (bus.en) begin
         cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
         if (tick)
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
   end

   // registered display drive; anode off forces dp off
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.nibble <= 4'h0;
         bus.an     <= '1;
         bus.dp     <= 1'b1;
      end else begin
         bus.nibble <= sv[idx];
         bus.an     <= lit ? ~(DIGITS'(1) << idx) : '1;
         bus.dp     <= lit ? ~sd[idx] : 1'b1;
      end
   end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed and randomized checks of seg_scan (DIGITS=4, DIV=4).
// The reference model tracks the scan as a single position in the 16-cycle
// frame and derives digit, guard and blanking from it arithmetically.
module tb_seg_scan;
   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int FRAME  = DIGITS * DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   seg_scan_if #(.DIGITS(DIGITS)) bus ();

   seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference state
   int          pos;
   logic [15:0] m_sv;
   logic [3:0]  m_sd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int msd_of(input logic [15:0] v);
      int m = 0;
      for (int i = 1; i < DIGITS; i++)
         if (v[4*i +: 4] != 4'h0) m = i;
      return m;
   endfunction

   task automatic model_reset();
      pos  = 0;
      m_sv = '0;
      m_sd = '0;
   endtask

   // one clock: drive inputs, predict, clock, check, advance the model
   task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic e);
      int         dig;
      bit         off;
      logic [3:0] e_nib;
      logic [3:0] e_an;
      logic       e_dp;
      bus.load  = ld;
      bus.value = v;
      bus.dp_in = d;
      bus.en    = e;
      dig = pos / DIV;
      off = !e || (pos % DIV == DIV - 1);
`ifdef SEG_SCAN_LZB_EN
      if (dig > msd_of(m_sv)) off = 1'b1;
`endif
      e_nib = m_sv[4*dig +: 4];
      e_an  = off ? 4'hF : ~(4'b0001 << dig);
      e_dp  = off ? 1'b1 : ~m_sd[dig];
      @(posedge clk);
      #1;
      chk("nibble", 32'(bus.nibble), 32'(e_nib));
      chk("an", 32'(bus.an), 32'(e_an));
      chk("dp", 32'(bus.dp), 32'(e_dp));
      if (ld) begin
         m_sv = v;
         m_sd = d;
      end
      if (e) pos = (pos + 1) % FRAME;
   endtask

   // asynchronous reset between edges; outputs must clear without a clock
   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_an", 32'(bus.an), 32'hF);
      chk("rst_nibble", 32'(bus.nibble), 32'h0);
      chk("rst_dp", 32'(bus.dp), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int   guard;
      logic ld;
      logic [15:0] v;
      bus.load  = 1'b0;
      bus.value = '0;
      bus.dp_in = '0;
      bus.en    = 1'b0;
      model_reset();

      // reset state
      #12;
      chk("reset_an", 32'(bus.an), 32'hF);
      chk("reset_nibble", 32'(bus.nibble), 32'h0);
      chk("reset_dp", 32'(bus.dp), 32'h1);
      @(negedge clk);
      rst = 1'b0;

      // basic scan with one decimal point, two full frames plus wrap
      step(1'b1, 16'h1234, 4'b0100, 1'b1);
      for (int i = 0; i < 2 * FRAME + 2; i++) step(1'b0, 16'h0, 4'b0, 1'b1);

      // freeze in the middle of digit 2's slot, then resume
      guard = 0;
      while (!(pos / DIV == 2 && pos % DIV == 1) && guard < 64) begin
         step(1'b0, 16'h0, 4'b0, 1'b1);
         guard++;
      end
      chk("freeze_reach", 32'(guard < 64), 32'h1);
      for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 4'b0, 1'b0);
      for (int i = 0; i < FRAME; i++) step(1'b0, 16'h0, 4'b0, 1'b1);

      // reset mid-scan, then load 1234 and replace it while digit 0 is lit
      mid_reset();
      step(1'b1, 16'h1234, 4'b0000, 1'b1);
      step(1'b1, 16'hABCD, 4'b0000, 1'b1);
      for (int i = 0; i < FRAME + 2; i++) step(1'b0, 16'h0, 4'b0, 1'b1);

      // load coinciding with a guard edge
      while (pos % DIV != DIV - 1) step(1'b0, 16'h0, 4'b0, 1'b1);
      step(1'b1, 16'h5E7F, 4'b1001, 1'b1);
      for (int i = 0; i < FRAME; i++) step(1'b0, 16'h0, 4'b0, 1'b1);

      // leading-zero patterns
      step(1'b1, 16'h0042, 4'b1111, 1'b1);
      for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'h0, 4'b0, 1'b1);
      step(1'b1, 16'h0000, 4'b0001, 1'b1);
      for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'h0, 4'b0, 1'b1);
      step(1'b1, 16'h0300, 4'b0000, 1'b0);
      for (int i = 0; i < FRAME; i++) step(1'b0, 16'h0, 4'b0, 1'b1);

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         ld = ($urandom_range(7) == 0);
         v  = 16'($urandom) >> (4 * $urandom_range(3));
         step(ld, v, 4'($urandom), ($urandom_range(9) != 0));
         if ($urandom_range(149) == 0) mid_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed display scanner feeding the hex-to-seven-segment decoder. Latches a multi-digit hex value and time-multiplexes it across a common-anode display: each refresh slot presents one 4-bit nibble to the decoder's `bin` input, drives the matching active-low anode, and drives the digit's decimal point. A one-cycle all-anodes-off guard at every digit change suppresses ghosting.

## Interface
- `DIGITS`, default 4: number of display digits; legal range 1..8.
- `DIV`, default 50000: clock cycles per digit slot; minimum 2.

- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `value`  in  4*DIGITS: hex value to display; nibble i (bits 4i+3..4i) goes to digit i; digit 0 is rightmost.
- `dp_in`  in  DIGITS: decimal-point request per digit, active-high.
- `load`  in  1: captures `value` and `dp_in` into shadow registers when sampled high.
- `en`  in  1: display enable; low blanks the display and freezes the scan.
- `nibble`  out  4: current digit's nibble, wired to the decoder's `bin`.
- `an`  out  DIGITS: anode selects, active-low, one-hot-low or all ones.
- `dp`  out  1: decimal point, active-low.

## Operation
- State: shadow value `sv` (4*DIGITS bits), shadow dp `sd` (DIGITS bits), prescaler `cnt` (0..DIV-1), digit index `idx` (0..DIGITS-1).
- `load` high at an edge: `sv<=value`, `sd<=dp_in`. Otherwise shadows hold. Loading is independent of `en`.
- `tick` = `en && cnt==DIV-1` (combinational, internal).
- `en` high: `cnt` increments, wrapping DIV-1 -> 0. On `tick`, `idx` advances, wrapping DIGITS-1 -> 0.
- `en` low: `cnt` and `idx` hold.
- Outputs are registered. Each edge:
  - `nibble<=sv[idx]`
  - `dp<=~sd[idx]`, forced to 1 when the anode is off
  - `an<=all ones` if `!en` or `tick` (guard cycle); otherwise `an<=~(1<<idx)`.
- Scan period is DIGITS*DIV cycles. Each digit is lit for DIV-1 cycles, followed by one guard cycle.
- DIGITS=1: `idx` stays 0; the guard cycle still occurs every DIV cycles.
- Reset values: `sv=0`, `sd=0`, `cnt=0`, `idx=0`, `nibble=0`, `an=all ones`, `dp=1`.

## Timing
- Load latency: with `load` sampled at edge k, the new nibble appears on `nibble` after edge k+1.
- Index latency: after a `tick` at edge k, `an` is all ones after edge k, and the new digit lights after edge k+1.
- `en` falling, sampled at edge k: `an=all ones` and `dp=1` after edge k. `en` rising: the same digit relights after the next edge and the slot count resumes where it stopped.
- Simultaneous `load` and `tick`: both take effect. The new digit shows new shadow data.
- `rst` mid-scan: all state returns to reset values immediately, independent of `clk`. The scan restarts at digit 0, `cnt=0`, after `rst` deasserts.

## Configuration
- `SEG_SCAN_LZB_EN` (leading-zero blanking):
  - Defined: digits above the most significant nonzero nibble of `sv` keep their anode high and `dp=1` during their slot. Digit 0 is never blanked. Slot timing is unchanged.
  - Undefined: every digit is displayed, including leading zeros.

## Test plan
- Reset: assert `rst` asynchronously between edges -> `an=4'b1111`, `nibble=0`, `dp=1` at once. Any nonzero `cnt` and `idx` values return to 0.
- Basic scan (DIV=4, DIGITS=4, `en=1`): load 16'h1234 -> digit slots in order:
  - `an=1110` with `nibble=4` for 3 cycles, then guard `an=1111`
  - `an=1101` with `nibble=3`, then `an=1011` with `nibble=2`, then `an=0111` with `nibble=1`
  - wraps back to `an=1110` after 16 cycles total.
- Decimal point: `dp_in=4'b0100` with the same load -> `dp=0` only while `an=1011`; `dp=1` in every other slot and in guard cycles.
- Enable/freeze: drop `en` during digit 2's slot -> `an=1111` on the next edge. Raise it 10 cycles later -> digit 2 relights and finishes its remaining slot cycles.
- Load mid-slot: load 16'hABCD while digit 0 is lit -> `nibble` changes from 4 to D within the same slot, on the second edge after `load` is sampled.
- Leading-zero blanking (with `SEG_SCAN_LZB_EN`):
  - 16'h0042 -> digits 2 and 3 never drive an anode low.
  - 16'h0000 -> only digit 0 lights, showing 0.
  - Without the macro, both values light all four digits.
